// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter paced by an oversampling strobe (sample_clk).
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1).
module uart_tx #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              at_boundary;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Handshake: a byte is taken on any clk edge where tx_valid && tx_ready;
  // tx_ready is low for the whole frame, so nothing offered while busy is seen.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    at_boundary = (state_q != ST_IDLE) && sample_clk && (tick_q == TICK_LAST);

    if (state_q != ST_IDLE && sample_clk) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          tick_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (at_boundary) begin
          state_d = ST_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (at_boundary) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = par_q;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (at_boundary) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (at_boundary) begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: bytes pushed on acceptance, a strobe-counting reference
// receiver pops them and checks the whole serial waveform and handshake.
module tb_uart_tx;

  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_clk;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic       tx_done;

  uart_tx #(.OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_clk (sample_clk),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #10 clk = ~clk;

  logic [7:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  idle_err = 0;
  int  cyc = 0;
  int  sc_period = 4;
  int  sc_cnt = 0;
  int  strobes = 0;
  int  nbits = 0;
  int  done_cyc = -100;
  int  frames_done = 0;
  int  n_sent = 0;
  int  n_aborted = 0;
  int  bad_at = 0;
  bit  in_frame = 1'b0;
  bit  prev_done = 1'b0;
  bit  gap_check = 1'b0;
  bit  frame_ok = 1'b0;
  logic [10:0] fb;
  logic [10:0] rx;
  logic [7:0]  cur_b;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit even_par(input logic [7:0] b);
    bit p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ b[i];
    return p;
  endfunction

  // Strobe source: one-clk pulse every sc_period clocks, changed at negedge.
  initial begin
    sample_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (sc_cnt >= sc_period - 1) begin
        sc_cnt = 0;
        sample_clk = 1'b1;
      end else begin
        sc_cnt++;
        sample_clk = 1'b0;
      end
    end
  end

  // Reference receiver: bit k of a frame spans strobes k*OS .. (k+1)*OS-1
  // counted after the acceptance edge; data is also read at mid-bit.
  initial begin
    int idx;
    logic [7:0] rxb;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n !== 1'b1) begin
        chk("reset_state", txd === 1'b1 && tx_ready === 1'b1 && busy === 1'b0 && tx_done === 1'b0,
            {28'd0, txd, tx_ready, busy, tx_done}, 32'hc);
        if (in_frame) n_aborted++;
        in_frame = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          chk("done_pulse", tx_done === 1'b0, tx_done, 0);
          prev_done = 1'b0;
        end
        if (!in_frame) begin
          if (txd === 1'b0) begin
            chk("frame_expected", exp_q.size() > 0, exp_q.size(), 1);
            if (exp_q.size() > 0) begin
              cur_b = exp_q.pop_front();
              fb = '1;
              fb[0] = 1'b0;
              for (int i = 0; i < 8; i++) fb[i+1] = cur_b[i];
`ifdef UART_TX_PARITY_EN
              fb[9] = even_par(cur_b);
              nbits = 11;
`else
              nbits = 10;
`endif
              strobes = 0;
              rx = '0;
              in_frame = 1'b1;
              frame_ok = (busy === 1'b1 && tx_ready === 1'b0 && tx_done === 1'b0);
              bad_at = frame_ok ? 0 : 1;
              if (gap_check) chk("b2b_gap", cyc - done_cyc == 1, cyc - done_cyc, 1);
              gap_check = 1'b0;
            end
          end else if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
            idle_err++;
          end
        end else begin
          if (sample_clk === 1'b1) strobes++;
          idx = strobes / OS;
          if (idx < nbits) begin
            if (txd !== fb[idx] || busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
              if (frame_ok) bad_at = strobes + 1000;
              frame_ok = 1'b0;
            end
            if (sample_clk === 1'b1 && (strobes % OS) == OS / 2) rx[idx] = txd;
          end else begin
            chk("waveform", frame_ok, bad_at, 0);
            chk("done_edge", tx_done === 1'b1 && tx_ready === 1'b1 && busy === 1'b0 && txd === 1'b1,
                {28'd0, tx_done, tx_ready, busy, txd}, 32'hd);
            for (int i = 0; i < 8; i++) rxb[i] = rx[i+1];
            chk("rx_byte", rxb === cur_b, rxb, cur_b);
            chk("stop_bit", rx[nbits-1] === 1'b1, rx[nbits-1], 1);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", rx[9] === even_par(cur_b), rx[9], even_par(cur_b));
`endif
            in_frame = 1'b0;
            prev_done = 1'b1;
            done_cyc = cyc;
            frames_done++;
          end
        end
      end
    end
  end

  // Leaves tx_valid high after the acceptance edge; b2b asks for the gap check.
  task automatic offer(input logic [7:0] b, input bit b2b);
    int t;
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    for (t = 0; t < 4000; t++) begin
      if (tx_ready === 1'b1) break;
      @(negedge clk);
    end
    if (t >= 4000) begin
      chk("accept_timeout", 1'b0, t, 0);
    end else begin
      exp_q.push_back(b);
      gap_check = b2b;
      n_sent++;
      @(posedge clk);
    end
  endtask

  task automatic drop_valid(input int n);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (!in_frame && busy === 1'b0) break;
    end
    chk("frame_complete", t < 4000, t, 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h55;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);

    sc_period = 4;
    offer(8'h55, 1'b0);
    drop_valid(0);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    offer(8'h07, 1'b0);
    drop_valid(0);
    wait_idle();
    offer(8'h55, 1'b0);
    drop_valid(0);
    wait_idle();
`endif

    offer(8'hA5, 1'b0);
    offer(8'h3C, 1'b1);
    drop_valid(0);
    wait_idle();

    offer(8'h00, 1'b0);
    drop_valid(40);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    repeat (60) @(negedge clk);
    offer(8'hFF, 1'b1);
    drop_valid(0);
    wait_idle();

    offer(8'h81, 1'b0);
    drop_valid(0);
    for (t = 0; t < 4000; t++) begin
      if (in_frame && strobes >= OS * 4 + 2) break;
      @(negedge clk);
    end
    chk("reach_d3", t < 4000, t, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    offer(8'h81, 1'b0);
    drop_valid(0);
    wait_idle();

    for (int k = 0; k < 16; k++) begin
      sc_period = $urandom_range(2, 6);
      if ($urandom_range(0, 3) == 0) begin
        offer(8'($urandom), 1'b1);
      end else begin
        drop_valid($urandom_range(0, 20));
        offer(8'($urandom), 1'b0);
      end
    end
    drop_valid(0);
    wait_idle();
    repeat (5) @(negedge clk);

    chk("idle_line", idle_err == 0, idle_err, 0);
    chk("drain", exp_q.size() == 0, exp_q.size(), 0);
    chk("aborted_frames", n_aborted == 1, n_aborted, 1);
    chk("frame_count", frames_done == n_sent - 1, frames_done, n_sent - 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
